// File: rtl/md_if.sv
// Issue/result bundle between the EX-stage control and the multiply/divide unit.
interface md_if;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output md_op, A, B, input busy, done, hi, lo);
  modport slave  (input md_op, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// mult/div run for a fixed latency; mthi/mtlo write in a single cycle.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  op_t         op_q, op_n;
  logic [31:0] a_q, a_n, b_q, b_n;
  logic [31:0] hi_q, hi_n, lo_q, lo_n;
  logic        done_q, done_n;

  logic [63:0] ext_a, ext_b, prod;
  logic        sdiv;
  logic [31:0] mag_a, mag_b, quo_u, rem_u, quo, rem;

  // Multiply in 64 bits on pre-extended operands so one multiplier covers both signednesses.
  always_comb begin
    ext_a = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    ext_b = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod  = ext_a * ext_b;
  end

  // Signed divide works on magnitudes; this keeps 0x80000000 / -1 well defined (LO wraps, HI=0).
  always_comb begin
    sdiv  = (op_q == OP_DIV);
    mag_a = (sdiv && a_q[31]) ? (32'd0 - a_q) : a_q;
    mag_b = (sdiv && b_q[31]) ? (32'd0 - b_q) : b_q;
    quo_u = '0;
    rem_u = '0;
    if (mag_b != '0) begin
      quo_u = mag_a / mag_b;
      rem_u = mag_a % mag_b;
    end
    quo = (sdiv && (a_q[31] ^ b_q[31])) ? (32'd0 - quo_u) : quo_u;
    rem = (sdiv && a_q[31]) ? (32'd0 - rem_u) : rem_u;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= OP_NONE;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      op_q   <= op_n;
      a_q    <= a_n;
      b_q    <= b_n;
      hi_q   <= hi_n;
      lo_q   <= lo_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        case (bus.md_op)
          OP_MULT, OP_MULTU: begin
            op_n    = op_t'(bus.md_op);
            a_n     = bus.A;
            b_n     = bus.B;
            cnt_n   = CW'(MULT_CYCLES);
            state_n = RUN;
          end
          OP_DIV, OP_DIVU: begin
            op_n    = op_t'(bus.md_op);
            a_n     = bus.A;
            b_n     = bus.B;
            cnt_n   = CW'(DIV_CYCLES);
            state_n = RUN;
          end
          OP_MTHI: hi_n = bus.A;
          OP_MTLO: lo_n = bus.A;
          default: ;
        endcase
      end
      RUN: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
          if (op_q == OP_MULT || op_q == OP_MULTU) begin
            hi_n = prod[63:32];
            lo_n = prod[31:0];
          end else if (b_q != '0) begin
            hi_n = rem;
            lo_n = quo;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized ops against a plain-arithmetic model.
module tb_md_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  md_if bus ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: architectural effect of one op on HI/LO, using 64-bit integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin sp = sa * sb; exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; exp_hi = up[63:32]; exp_lo = up[31:0]; end
      3'd3: if (b != 0) begin sq = sa / sb; sr = sa % sb; exp_lo = sq[31:0]; exp_hi = sr[31:0]; end
      3'd4: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
      3'd5: exp_hi = a;
      3'd6: exp_lo = a;
      default: ;
    endcase
  endfunction

  // Issue at the current negedge, scramble operands afterwards, return busy length and done in the first idle cycle.
  task automatic exec_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int blen, output logic dpulse);
    bus.md_op = op; bus.A = a; bus.B = b;
    model(op, a, b);
    @(negedge clk);
    bus.md_op = 3'd0; bus.A = $urandom; bus.B = $urandom;
    blen = 0;
    while (bus.busy === 1'b1 && blen < 64) begin
      blen++;
      @(negedge clk);
      bus.A = $urandom; bus.B = $urandom;
    end
    dpulse = bus.done;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.md_op = 3'd1; bus.A = $urandom; bus.B = $urandom;
    @(negedge clk); @(negedge clk);
    reset = 1'b0; bus.md_op = 3'd0;
    exp_hi = '0; exp_lo = '0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
    n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_op_dropped: busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_mult();
    int blen; logic dp; logic [2:0] op; logic [31:0] a, b;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin op = 3'd1; a = 32'hFFFFFFFE; b = 32'd3; end
      else if (i == 1) begin op = 3'd2; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
      else if (i == 2) begin op = 3'd1; a = 32'h80000000; b = 32'h80000000; end
      else begin op = 3'(1 + $urandom_range(0, 1)); a = $urandom; b = $urandom; end
      exec_op(op, a, b, blen, dp);
      n_checks++; if (blen != 5) begin n_fail++; $display("FAIL mult_busy_len[%0d]: got %0d expected 5", i, blen); end
      n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL mult_done[%0d]: got %b expected 1", i, dp); end
      n_checks++; if (bus.hi !== exp_hi) begin n_fail++; $display("FAIL mult_hi[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, bus.hi, exp_hi); end
      n_checks++; if (bus.lo !== exp_lo) begin n_fail++; $display("FAIL mult_lo[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, bus.lo, exp_lo); end
      @(negedge clk);
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse[%0d]: got %b expected 0", i, bus.done); end
    end
  endtask

  task automatic test_div();
    int blen; logic dp; logic [2:0] op; logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      case (i)
        0: begin op = 3'd3; a = 32'hFFFFFFF9; b = 32'd2; end
        1: begin op = 3'd4; a = 32'hFFFFFFF9; b = 32'd2; end
        2: begin op = 3'd3; a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: begin op = 3'd4; a = $urandom; b = 32'd0; end
        4: begin op = 3'd3; a = 32'd7; b = 32'hFFFFFFFE; end
        default: begin
          op = 3'(3 + $urandom_range(0, 1)); a = $urandom;
          b = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 100)) : $urandom);
          if ($urandom_range(0, 1) == 1 && op == 3'd3) b = 32'd0 - b;
        end
      endcase
      exec_op(op, a, b, blen, dp);
      n_checks++; if (blen != 10) begin n_fail++; $display("FAIL div_busy_len[%0d]: got %0d expected 10", i, blen); end
      n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL div_done[%0d]: got %b expected 1", i, dp); end
      n_checks++; if (bus.hi !== exp_hi) begin n_fail++; $display("FAIL div_hi[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, bus.hi, exp_hi); end
      n_checks++; if (bus.lo !== exp_lo) begin n_fail++; $display("FAIL div_lo[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, bus.lo, exp_lo); end
      @(negedge clk);
    end
  endtask

  task automatic test_mtx();
    int blen; logic dp;
    bus.md_op = 3'd5; bus.A = 32'h12345678; model(3'd5, 32'h12345678, 32'd0);
    @(negedge clk);
    bus.md_op = 3'd6; bus.A = 32'h9ABCDEF0; model(3'd6, 32'h9ABCDEF0, 32'd0);
    n_checks++; if (bus.hi !== exp_hi) begin n_fail++; $display("FAIL mthi_hi: got %h expected %h", bus.hi, exp_hi); end
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL mthi_flags: busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    @(negedge clk);
    bus.md_op = 3'd0;
    n_checks++; if (bus.lo !== exp_lo) begin n_fail++; $display("FAIL mtlo_lo: got %h expected %h", bus.lo, exp_lo); end
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL mtlo_flags: busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    exec_op(3'd3, $urandom, 32'd0, blen, dp);
    n_checks++; if (blen != 10) begin n_fail++; $display("FAIL divzero_busy_len: got %0d expected 10", blen); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL divzero_done: got %b expected 1", dp); end
    n_checks++; if (bus.hi !== exp_hi) begin n_fail++; $display("FAIL divzero_hi: got %h expected %h", bus.hi, exp_hi); end
    n_checks++; if (bus.lo !== exp_lo) begin n_fail++; $display("FAIL divzero_lo: got %h expected %h", bus.lo, exp_lo); end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int blen; logic stop; logic [31:0] a, b;
    a = $urandom; b = $urandom;
    bus.md_op = 3'd1; bus.A = a; bus.B = b;
    model(3'd1, a, b);
    blen = 0; stop = 1'b0;
    for (int i = 1; i <= 64 && !stop; i++) begin
      @(negedge clk);
      bus.md_op = (i == 2) ? 3'd6 : ((i == 3) ? 3'd4 : 3'd0);
      bus.A = (i == 2) ? 32'hDEADBEEF : $urandom;
      bus.B = (i == 3) ? 32'd0 : $urandom;
      if (bus.busy === 1'b1) blen++;
      else stop = 1'b1;
    end
    bus.md_op = 3'd0;
    n_checks++; if (blen != 5) begin n_fail++; $display("FAIL ignore_busy_len: got %0d expected 5", blen); end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ignore_done: got %b expected 1", bus.done); end
    n_checks++; if (bus.lo !== exp_lo) begin n_fail++; $display("FAIL ignore_lo: got %h expected %h", bus.lo, exp_lo); end
    n_checks++; if (bus.hi !== exp_hi) begin n_fail++; $display("FAIL ignore_hi: got %h expected %h", bus.hi, exp_hi); end
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_restart: busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int bl1, bl2; logic d1, d2;
    exec_op(3'd1, $urandom, $urandom, bl1, d1);
    n_checks++; if (bl1 != 5 || d1 !== 1'b1) begin n_fail++; $display("FAIL b2b_first: len=%0d done=%b expected 5 1", bl1, d1); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: busy got %b expected 0", bus.busy); end
    exec_op(3'd4, $urandom, 32'($urandom_range(1, 1000)), bl2, d2);
    n_checks++; if (bl2 != 10) begin n_fail++; $display("FAIL b2b_second_len: got %0d expected 10", bl2); end
    n_checks++; if (d2 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b expected 1", d2); end
    n_checks++; if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin n_fail++; $display("FAIL b2b_result: got %h/%h expected %h/%h", bus.hi, bus.lo, exp_hi, exp_lo); end
    @(negedge clk);
  endtask

  task automatic test_reset_run();
    logic stray;
    bus.md_op = 3'd3; bus.A = $urandom; bus.B = 32'd3;
    @(negedge clk); bus.md_op = 3'd0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin n_fail++; $display("FAIL abort_hilo: got %h/%h expected 0/0", bus.hi, bus.lo); end
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) stray = 1'b1;
    end
    n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL abort_no_late_done: activity got %b expected 0", stray); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    bus.md_op = 3'd0; bus.A = '0; bus.B = '0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_mtx();
    test_ignore_busy();
    test_back_to_back();
    test_reset_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage, directly upstream of the data memory stage.
- Executes mult, multu, div and divu as multi-cycle operations into the architectural HI/LO registers.
- Executes mthi and mtlo in a single cycle.
- Exposes busy so the hazard unit can stall later md instructions and mfhi/mflo in D.
- Supplies hi/lo to the EX result mux; mfhi/mflo values then travel through the EX/MEM register as regdata into the memory stage.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (must be >=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- md_op  input  3  operation issued this cycle: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 treated as none.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- busy  output  1  a multi-cycle operation is in flight.
- done  output  1  one-cycle pulse; HI/LO were updated by a completed mult/div at the preceding edge.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Only clk and reset (synchronous, active-high).
- Reset values: busy=0, done=0, hi=0, lo=0, counter=0. Any pending result is discarded.
- State: IDLE / RUN, plus a down-counter, latched op and latched A/B.
- hi and lo are driven straight from the registers, with no combinational bypass.

Issue, IDLE with md_op in 1..4 at edge N:
- Latch op, A and B.
- Load counter with MULT_CYCLES or DIV_CYCLES.
- Enter RUN; busy=1 from cycle N+1.

Completion in RUN:
- Each edge decrements the counter.
- At the edge where the counter goes 1->0, write HI/LO, return to IDLE, busy=0 and done=1 for exactly one cycle.
- busy is therefore high for exactly MULT_CYCLES or DIV_CYCLES cycles.

Arithmetic:
- mult: signed 32x32->64, HI=[63:32], LO=[31:0].
- multu: unsigned 32x32->64, same split.
- div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
- divu: unsigned; LO=quotient, HI=remainder.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (div or divu): full latency, busy and done behave normally, HI/LO unchanged.

mthi/mtlo:
- In IDLE, write A into HI (mthi) or LO (mtlo) at the edge; visible the next cycle.
- No busy and no done.

Boundary conditions:
- md_op != 0 while busy: ignored, with no effect on state, HI/LO or counter. The hazard unit guarantees stall; the block does not rely on it.
- md_op in 1..4 in the same cycle done is high (already IDLE): accepted normally, so back-to-back ops have a 1-cycle gap in busy.
- A and B changing after issue: no effect, operands are latched.
- reset during RUN: abort immediately; next cycle all outputs are at reset values.
- reset together with md_op: reset wins, op dropped.

Test Plan:
- Reset, then mult A=0xFFFFFFFE (-2), B=3 at edge 0 -> busy=1 during cycles 1..5, done=1 in cycle 6; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001; done a single-cycle pulse.
- div A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 -> hi/lo update one edge after each, busy stays 0. Then div by B=0 -> busy for 10 cycles, HI/LO still 0x12345678 / 0x9ABCDEF0.
- Issue mult; at cycle 2 drive md_op=mtlo, A=0xDEADBEEF -> ignored, LO gets only the mult result. Issue divu in the done cycle -> accepted, busy 0 for exactly that cycle.
- Start div, assert reset in cycle 4 -> after the edge busy=0, done=0, hi=lo=0, and no later done pulse.
